// File: rtl/gs_pkg.sv
// Shared types and constants for the xAyB guess/score controller and its entry checker.
package gs_pkg;

    localparam int          N_DIGITS  = 3;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;

    typedef logic [3:0] digit_t;

    // Element 0 is the most significant entered position (iNum1).
    typedef digit_t [N_DIGITS-1:0] digits_t;

    typedef enum logic [2:0] {
        WAIT_SECRET,
        WAIT_GUESS,
        SCORE,
        WIN,
        LOSE
    } state_e;

endpackage

// File: rtl/guess_score_ctrl_if.sv
// Keypad-entry inputs and score/status outputs of the guess/score controller.
interface guess_score_ctrl_if #(
    parameter int CNT_W = 4
);

    logic [3:0]       iNum1;
    logic [3:0]       iNum2;
    logic [3:0]       iNum3;
    logic             iNumRdy;
    logic             iNewGame;

    logic             oSecretSet;
    logic             oBusy;
    logic [1:0]       oA;
    logic [1:0]       oB;
    logic             oScoreVld;
    logic [CNT_W-1:0] oGuessCnt;
    logic [3:0]       oGuess1;
    logic [3:0]       oGuess2;
    logic [3:0]       oGuess3;
    logic             oBadInput;
    logic             oWin;
    logic             oLose;

    modport master (
        output iNum1, iNum2, iNum3, iNumRdy, iNewGame,
        input  oSecretSet, oBusy, oA, oB, oScoreVld, oGuessCnt,
               oGuess1, oGuess2, oGuess3, oBadInput, oWin, oLose
    );

    modport slave (
        input  iNum1, iNum2, iNum3, iNumRdy, iNewGame,
        output oSecretSet, oBusy, oA, oB, oScoreVld, oGuessCnt,
               oGuess1, oGuess2, oGuess3, oBadInput, oWin, oLose
    );

endinterface

// File: rtl/guess_score_ctrl_guess_check.sv
// Combinational entry checker: every digit in 0..9 and all digits pairwise distinct.
module guess_check
    import gs_pkg::*;
(
    input  digits_t digits_i,
    output logic    valid_o
);

    always_comb begin
        // NOTE: valid_o is given a default before any conditional update so no latch is inferred.
        valid_o = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digits_i[i] > DIGIT_MAX) valid_o = 1'b0;
            for (int j = i + 1; j < N_DIGITS; j++) begin
                if (digits_i[i] == digits_i[j]) valid_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/guess_score_ctrl.sv
// Sequencing controller for the xAyB game: latches a secret, scores guesses one digit
// per cycle, counts guesses and declares win/lose.
module guess_score_ctrl
    import gs_pkg::*;
#(
    parameter int MAX_GUESS = 10,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    guess_score_ctrl_if.slave  bus
);

    localparam logic [1:0]       LAST_IDX = 2'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_GUESS);

    state_e           state_q, state_d;
    logic             rdy_q;
    digits_t          secret_q, secret_d;
    digits_t          guess_q, guess_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       acc_a_q, acc_a_d;
    logic [1:0]       acc_b_q, acc_b_d;
    logic [1:0]       a_q, a_d;
    logic [1:0]       b_q, b_d;
    logic             vld_q, vld_d;
    logic             bad_q, bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    digits_t          entry;
    logic             entry_ev;
    logic             entry_ok;
    digit_t           cur_g;
    logic             hit_a, hit_b, in_secret;
    logic [1:0]       a_fin, b_fin;
    logic             last_digit;
    logic [CNT_W-1:0] cnt_inc;

    assign entry    = {bus.iNum3, bus.iNum2, bus.iNum1};
    assign entry_ev = bus.iNumRdy & ~rdy_q;

    guess_check u_check (
        .digits_i (entry),
        .valid_o  (entry_ok)
    );

    // Scoring of the digit selected by idx_q against the whole secret.
    always_comb begin
        cur_g     = guess_q[idx_q];
        in_secret = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cur_g == secret_q[i]) in_secret = 1'b1;
        end
        hit_a      = (cur_g == secret_q[idx_q]);
        hit_b      = ~hit_a & in_secret;
        a_fin      = acc_a_q + {1'b0, hit_a};
        b_fin      = acc_b_q + {1'b0, hit_b};
        last_digit = (idx_q == LAST_IDX);
        cnt_inc    = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state_q <= WAIT_SECRET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.iNewGame) begin
            state_d = WAIT_SECRET;
        end else begin
            unique case (state_q)
                WAIT_SECRET: if (entry_ev && entry_ok) state_d = WAIT_GUESS;
                WAIT_GUESS:  if (entry_ev && entry_ok) state_d = SCORE;
                SCORE: begin
                    if (last_digit) begin
                        if (a_fin == 2'(N_DIGITS))  state_d = WIN;
                        else if (cnt_inc == CNT_MAX) state_d = LOSE;
                        else                         state_d = WAIT_GUESS;
                    end
                end
                WIN, LOSE: state_d = state_q;
                default:   state_d = WAIT_SECRET;
            endcase
        end
    end

    always_comb begin
        secret_d = secret_q;
        guess_d  = guess_q;
        idx_d    = idx_q;
        acc_a_d  = acc_a_q;
        acc_b_d  = acc_b_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        vld_d    = 1'b0;
        bad_d    = 1'b0;
        if (bus.iNewGame) begin
            secret_d = '0;
            guess_d  = '0;
            idx_d    = '0;
            acc_a_d  = '0;
            acc_b_d  = '0;
            a_d      = '0;
            b_d      = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                WAIT_SECRET: begin
                    if (entry_ev) begin
                        if (entry_ok) secret_d = entry;
                        else          bad_d    = 1'b1;
                    end
                end
                WAIT_GUESS: begin
                    if (entry_ev) begin
                        if (entry_ok) begin
                            guess_d = entry;
                            idx_d   = '0;
                            acc_a_d = '0;
                            acc_b_d = '0;
                        end else begin
                            bad_d = 1'b1;
                        end
                    end
                end
                SCORE: begin
                    acc_a_d = a_fin;
                    acc_b_d = b_fin;
                    idx_d   = idx_q + 2'd1;
                    if (last_digit) begin
                        idx_d = '0;
                        a_d   = a_fin;
                        b_d   = b_fin;
                        vld_d = 1'b1;
                        cnt_d = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q    <= 1'b0;
            secret_q <= '0;
            guess_q  <= '0;
            idx_q    <= '0;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            // Tracks the raw level even across a restart so a held key cannot retrigger.
            rdy_q    <= bus.iNumRdy;
            secret_q <= secret_d;
            guess_q  <= guess_d;
            idx_q    <= idx_d;
            acc_a_q  <= acc_a_d;
            acc_b_q  <= acc_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            bad_q    <= bad_d;
        end
    end

    always_comb begin
        bus.oSecretSet = (state_q != WAIT_SECRET);
        bus.oBusy      = (state_q == SCORE);
        bus.oWin       = (state_q == WIN);
        bus.oLose      = (state_q == LOSE);
        bus.oA         = a_q;
        bus.oB         = b_q;
        bus.oScoreVld  = vld_q;
        bus.oBadInput  = bad_q;
        bus.oGuessCnt  = cnt_q;
        bus.oGuess1    = guess_q[0];
        bus.oGuess2    = guess_q[1];
        bus.oGuess3    = guess_q[2];
    end

endmodule

// File: tb/tb_guess_score_ctrl.sv
// Self-checking bench for guess_score_ctrl: directed scenarios plus randomized games
// compared against a transaction-level model of the xAyB rules.
module tb_guess_score_ctrl;

    localparam int MAXG = 3;
    localparam int CW   = 4;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    guess_score_ctrl_if #(.CNT_W(CW)) bus ();

    guess_score_ctrl #(.MAX_GUESS(MAXG), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game model: one call per entry event, applying the rules directly.
    bit m_set, m_win, m_lose;
    int m_sec[3];
    int m_g[3];
    int m_cnt, m_a, m_b;

    task automatic model_clear();
        m_set = 0; m_win = 0; m_lose = 0;
        m_cnt = 0; m_a = 0; m_b = 0;
        m_sec = '{0, 0, 0};
        m_g   = '{0, 0, 0};
    endtask

    // Returns 0 ignored, 1 rejected, 2 secret latched, 3 guess scored.
    function automatic int model_entry(input int d0, input int d1, input int d2);
        int d[3];
        int a, common;
        d[0] = d0; d[1] = d1; d[2] = d2;
        if (m_win || m_lose) return 0;
        if (d0 > 9 || d1 > 9 || d2 > 9 || d0 == d1 || d0 == d2 || d1 == d2) return 1;
        if (!m_set) begin
            m_set = 1;
            m_sec = d;
            return 2;
        end
        a = 0; common = 0;
        for (int i = 0; i < 3; i++) begin
            if (d[i] == m_sec[i]) a++;
            for (int j = 0; j < 3; j++) if (d[i] == m_sec[j]) common++;
        end
        m_g = d;
        m_a = a;
        m_b = common - a;
        if (m_cnt < MAXG) m_cnt++;
        if (a == 3) m_win = 1;
        else if (m_cnt == MAXG) m_lose = 1;
        return 3;
    endfunction

    // Observations gathered over a fixed window after one entry edge (index 0 = after E0).
    int ob_bad, ob_vld, ob_vld_at, ob_busy, ob_a, ob_b, ob_pre_a, ob_pre_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_entry(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        bus.iNum1 = d1; bus.iNum2 = d2; bus.iNum3 = d3;
        bus.iNumRdy = 1'b1;
        tick();
        bus.iNumRdy = 1'b0;
        ob_bad = 0; ob_vld = 0; ob_vld_at = -1; ob_busy = 0;
        ob_a = -1; ob_b = -1; ob_pre_a = -1; ob_pre_b = -1;
        for (int i = 0; i < 6; i++) begin
            if (bus.oBadInput) ob_bad++;
            if (bus.oBusy) ob_busy++;
            if (i == 2) begin ob_pre_a = int'(bus.oA); ob_pre_b = int'(bus.oB); end
            if (bus.oScoreVld) begin
                ob_vld++; ob_vld_at = i;
                ob_a = int'(bus.oA); ob_b = int'(bus.oB);
            end
            tick();
        end
    endtask

    task automatic do_newgame();
        bus.iNewGame = 1'b1;
        tick();
        bus.iNewGame = 1'b0;
        model_clear();
    endtask

    function automatic logic outs_zero();
        return ({bus.oSecretSet, bus.oBusy, bus.oA, bus.oB, bus.oScoreVld, bus.oGuessCnt,
                 bus.oGuess1, bus.oGuess2, bus.oGuess3, bus.oBadInput, bus.oWin, bus.oLose} == '0);
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        bus.iNum1 = '0; bus.iNum2 = '0; bus.iNum3 = '0;
        bus.iNumRdy = 1'b0; bus.iNewGame = 1'b0;
        model_clear();
        repeat (3) tick();
        checks++; if (outs_zero() !== 1'b1) begin errors++; $display("FAIL reset_outputs: outputs not all zero during reset"); end
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (outs_zero() !== 1'b1) begin errors++; $display("FAIL reset_idle: outputs changed with no input, secret_set=%0b", bus.oSecretSet); end
    endtask

    task automatic test_basic_score();
        run_entry(4'd1, 4'd2, 4'd3);
        checks++; if (bus.oSecretSet !== 1'b1 || ob_vld !== 0 || ob_bad !== 0) begin errors++; $display("FAIL secret_latch: set=%0b vld=%0d bad=%0d want 1/0/0", bus.oSecretSet, ob_vld, ob_bad); end
        run_entry(4'd1, 4'd3, 4'd2);
        checks++; if (ob_vld !== 1 || ob_vld_at !== 3) begin errors++; $display("FAIL basic_latency: pulses=%0d at=%0d want 1 at 3", ob_vld, ob_vld_at); end
        checks++; if (ob_a !== 1 || ob_b !== 2) begin errors++; $display("FAIL basic_ab: A=%0d B=%0d want 1/2", ob_a, ob_b); end
        checks++; if (int'(bus.oGuessCnt) !== 1 || ob_busy !== 3) begin errors++; $display("FAIL basic_cnt_busy: cnt=%0d busy=%0d want 1/3", bus.oGuessCnt, ob_busy); end
        checks++; if ({bus.oGuess1, bus.oGuess2, bus.oGuess3} !== 12'h132) begin errors++; $display("FAIL basic_echo: got %h want 132", {bus.oGuess1, bus.oGuess2, bus.oGuess3}); end
    endtask

    task automatic test_win();
        do_newgame();
        checks++; if (outs_zero() !== 1'b1) begin errors++; $display("FAIL newgame_clear: outputs not zero after restart"); end
        run_entry(4'd1, 4'd2, 4'd3);
        run_entry(4'd4, 4'd5, 4'd6);
        checks++; if (ob_vld !== 1 || ob_a !== 0 || ob_b !== 0) begin errors++; $display("FAIL miss_ab: vld=%0d A=%0d B=%0d want 1/0/0", ob_vld, ob_a, ob_b); end
        run_entry(4'd1, 4'd2, 4'd3);
        checks++; if (ob_a !== 3 || ob_b !== 0 || ob_pre_a !== 0) begin errors++; $display("FAIL win_ab: A=%0d B=%0d heldA=%0d want 3/0/0", ob_a, ob_b, ob_pre_a); end
        checks++; if (bus.oWin !== 1'b1 || bus.oLose !== 1'b0 || int'(bus.oGuessCnt) !== 2) begin errors++; $display("FAIL win_flag: win=%0b lose=%0b cnt=%0d want 1/0/2", bus.oWin, bus.oLose, bus.oGuessCnt); end
        run_entry(4'd7, 4'd8, 4'd9);
        checks++; if (ob_vld !== 0 || ob_bad !== 0 || int'(bus.oGuessCnt) !== 2 || bus.oWin !== 1'b1) begin errors++; $display("FAIL win_ignore: vld=%0d bad=%0d cnt=%0d win=%0b", ob_vld, ob_bad, bus.oGuessCnt, bus.oWin); end
        run_entry(4'd1, 4'd1, 4'd1);
        checks++; if (ob_bad !== 0) begin errors++; $display("FAIL win_bad_ignore: bad pulses=%0d want 0", ob_bad); end
    endtask

    task automatic test_bad_input();
        do_newgame();
        run_entry(4'd9, 4'd9, 4'd0);
        checks++; if (ob_bad !== 1 || bus.oSecretSet !== 1'b0) begin errors++; $display("FAIL bad_secret: bad=%0d set=%0b want 1/0", ob_bad, bus.oSecretSet); end
        run_entry(4'd0, 4'd9, 4'd8);
        checks++; if (ob_bad !== 0 || bus.oSecretSet !== 1'b1) begin errors++; $display("FAIL digit9_secret: bad=%0d set=%0b want 0/1", ob_bad, bus.oSecretSet); end
        run_entry(4'd1, 4'd1, 4'd4);
        checks++; if (ob_bad !== 1 || ob_vld !== 0) begin errors++; $display("FAIL bad_dup: bad=%0d vld=%0d want 1/0", ob_bad, ob_vld); end
        run_entry(4'd2, 4'd10, 4'd3);
        checks++; if (ob_bad !== 1 || ob_vld !== 0 || int'(bus.oGuessCnt) !== 0) begin errors++; $display("FAIL bad_range: bad=%0d vld=%0d cnt=%0d want 1/0/0", ob_bad, ob_vld, bus.oGuessCnt); end
        run_entry(4'd8, 4'd0, 4'd9);
        checks++; if (ob_vld !== 1 || ob_a !== 0 || ob_b !== 3 || int'(bus.oGuessCnt) !== 1) begin errors++; $display("FAIL after_bad_guess: vld=%0d A=%0d B=%0d cnt=%0d want 1/0/3/1", ob_vld, ob_a, ob_b, bus.oGuessCnt); end
    endtask

    task automatic test_lose();
        do_newgame();
        run_entry(4'd1, 4'd2, 4'd3);
        for (int g = 1; g <= 3; g++) begin
            run_entry(4'd4, 4'd5, 4'd6);
            checks++; if (ob_vld !== 1 || int'(bus.oGuessCnt) !== g || bus.oLose !== (g == 3)) begin errors++; $display("FAIL lose_g%0d: vld=%0d cnt=%0d lose=%0b", g, ob_vld, bus.oGuessCnt, bus.oLose); end
        end
        run_entry(4'd1, 4'd2, 4'd3);
        checks++; if (ob_vld !== 0 || bus.oWin !== 1'b0 || bus.oLose !== 1'b1 || int'(bus.oGuessCnt) !== 3) begin errors++; $display("FAIL lose_ignore: vld=%0d win=%0b lose=%0b cnt=%0d", ob_vld, bus.oWin, bus.oLose, bus.oGuessCnt); end
    endtask

    task automatic test_hold_and_drop();
        int pulses, a, b;
        do_newgame();
        run_entry(4'd1, 4'd2, 4'd3);
        bus.iNum1 = 4'd3; bus.iNum2 = 4'd2; bus.iNum3 = 4'd1;
        bus.iNumRdy = 1'b1;
        pulses = 0; a = -1; b = -1;
        for (int i = 0; i < 26; i++) begin
            if (i == 20) bus.iNumRdy = 1'b0;
            tick();
            if (bus.oScoreVld) begin pulses++; a = int'(bus.oA); b = int'(bus.oB); end
        end
        checks++; if (pulses !== 1 || a !== 1 || b !== 2 || int'(bus.oGuessCnt) !== 1) begin errors++; $display("FAIL hold_rdy: pulses=%0d A=%0d B=%0d cnt=%0d want 1/1/2/1", pulses, a, b, bus.oGuessCnt); end

        do_newgame();
        run_entry(4'd1, 4'd2, 4'd3);
        bus.iNum1 = 4'd4; bus.iNum2 = 4'd5; bus.iNum3 = 4'd6;
        bus.iNumRdy = 1'b1;
        tick();
        bus.iNumRdy = 1'b0;
        bus.iNum1 = 4'd1; bus.iNum2 = 4'd2; bus.iNum3 = 4'd3;
        tick();
        bus.iNumRdy = 1'b1;
        tick();
        bus.iNumRdy = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.oScoreVld) pulses++;
            if (bus.oBadInput) pulses += 10;
            tick();
        end
        checks++; if (pulses !== 1 || int'(bus.oGuessCnt) !== 1 || bus.oWin !== 1'b0 || bus.oA !== 2'd0) begin errors++; $display("FAIL drop_in_score: pulses=%0d cnt=%0d win=%0b A=%0d want 1/1/0/0", pulses, bus.oGuessCnt, bus.oWin, bus.oA); end
    endtask

    task automatic test_abort();
        int pulses;
        do_newgame();
        run_entry(4'd1, 4'd2, 4'd3);
        bus.iNum1 = 4'd1; bus.iNum2 = 4'd3; bus.iNum3 = 4'd2;
        bus.iNumRdy = 1'b1;
        tick();
        bus.iNumRdy = 1'b0;
        tick();
        #3 reset = 1'b0;
        #1;
        checks++; if (outs_zero() !== 1'b1) begin errors++; $display("FAIL async_reset: outputs not zero right after reset assert, busy=%0b", bus.oBusy); end
        tick();
        #2 reset = 1'b1;
        model_clear();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.oScoreVld) pulses++; end
        checks++; if (pulses !== 0 || outs_zero() !== 1'b1) begin errors++; $display("FAIL reset_midscore: pulses=%0d cnt=%0d want 0 and all zero", pulses, bus.oGuessCnt); end
        run_entry(4'd4, 4'd5, 4'd6);
        run_entry(4'd4, 4'd5, 4'd6);
        checks++; if (ob_a !== 3 || bus.oWin !== 1'b1) begin errors++; $display("FAIL reset_new_secret: A=%0d win=%0b want 3/1", ob_a, bus.oWin); end

        do_newgame();
        run_entry(4'd1, 4'd2, 4'd3);
        bus.iNum1 = 4'd1; bus.iNum2 = 4'd3; bus.iNum3 = 4'd2;
        bus.iNumRdy = 1'b1;
        tick();
        bus.iNumRdy = 1'b0;
        tick();
        bus.iNewGame = 1'b1;
        tick();
        bus.iNewGame = 1'b0;
        checks++; if (outs_zero() !== 1'b1) begin errors++; $display("FAIL newgame_midscore: outputs not zero, busy=%0b set=%0b", bus.oBusy, bus.oSecretSet); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin if (bus.oScoreVld) pulses++; tick(); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL newgame_novld: pulses=%0d want 0", pulses); end

        bus.iNum1 = 4'd7; bus.iNum2 = 4'd8; bus.iNum3 = 4'd9;
        bus.iNumRdy = 1'b1; bus.iNewGame = 1'b1;
        tick();
        bus.iNumRdy = 1'b0; bus.iNewGame = 1'b0;
        tick();
        checks++; if (bus.oSecretSet !== 1'b0 || bus.oBadInput !== 1'b0) begin errors++; $display("FAIL newgame_discard: set=%0b bad=%0b want 0/0", bus.oSecretSet, bus.oBadInput); end
        model_clear();
        run_entry(4'd5, 4'd6, 4'd7);
        run_entry(4'd5, 4'd6, 4'd7);
        checks++; if (ob_a !== 3 || bus.oWin !== 1'b1 || int'(bus.oGuessCnt) !== 1) begin errors++; $display("FAIL newgame_new_secret: A=%0d win=%0b cnt=%0d want 3/1/1", ob_a, bus.oWin, bus.oGuessCnt); end
    endtask

    task automatic test_random();
        int d[3];
        int kind;
        do_newgame();
        for (int n = 0; n < 60; n++) begin
            if ((m_win || m_lose) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0)) do_newgame();
            for (int k = 0; k < 3; k++) d[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 5));
            kind = model_entry(d[0], d[1], d[2]);
            run_entry(4'(d[0]), 4'(d[1]), 4'(d[2]));
            checks++; if (ob_bad !== ((kind == 1) ? 1 : 0) || ob_vld !== ((kind == 3) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_kind: bad=%0d vld=%0d model kind=%0d", n, ob_bad, ob_vld, kind); end
            if (kind == 3) begin
                checks++; if (ob_vld_at !== 3 || ob_a !== m_a || ob_b !== m_b) begin errors++; $display("FAIL rnd%0d_score: at=%0d A=%0d B=%0d want 3/%0d/%0d", n, ob_vld_at, ob_a, ob_b, m_a, m_b); end
            end
            checks++; if (int'(bus.oGuessCnt) !== m_cnt || bus.oWin !== m_win || bus.oLose !== m_lose || bus.oSecretSet !== m_set) begin errors++; $display("FAIL rnd%0d_state: cnt=%0d win=%0b lose=%0b set=%0b want %0d/%0b/%0b/%0b", n, bus.oGuessCnt, bus.oWin, bus.oLose, bus.oSecretSet, m_cnt, m_win, m_lose, m_set); end
            checks++; if (int'(bus.oGuess1) !== m_g[0] || int'(bus.oGuess2) !== m_g[1] || int'(bus.oGuess3) !== m_g[2] || int'(bus.oA) !== m_a || int'(bus.oB) !== m_b) begin errors++; $display("FAIL rnd%0d_echo: guess=%h A=%0d B=%0d want %0d%0d%0d/%0d/%0d", n, {bus.oGuess1, bus.oGuess2, bus.oGuess3}, bus.oA, bus.oB, m_g[0], m_g[1], m_g[2], m_a, m_b); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_score();
        test_win();
        test_bad_input();
        test_lose();
        test_hold_and_drop();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
